// File: rtl/imem_loader.sv
// imem_loader: boot/reload controller that streams bytes into the byte-addressed
//   instruction memory and gates the core fetch path while a load runs.
// Latency: a byte accepted on edge N is written to memory on edge N+1; one byte/cycle sustained.
// Backpressure: byte_ready is high only while loading; the host holds byte_valid until accepted.
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-high reset
//   load_start, load_len     load request and length in 32-bit instructions (sampled in IDLE only)
//   byte_valid/ready/data    host byte stream handshake
//   core_addr/instr/stall    core fetch interface (NOP substituted and stall held while busy)
//   mem_raddr/rdata          instruction memory read port (combinational read data)
//   mem_we/waddr/wdata       instruction memory byte write port (registered)
//   busy, done, err          status: load in progress, completion pulse, rejected-start pulse
module imem_loader #(
    parameter int          NUM_INSTR = 32,   // must be >= 2
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load_start,
    input  logic [15:0] load_len,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic        byte_ready,
    input  logic [31:0] core_addr,
    output logic [31:0] core_instr,
    output logic        core_stall,
    output logic [31:0] mem_raddr,
    input  logic [31:0] mem_rdata,
    output logic        mem_we,
    output logic [31:0] mem_waddr,
    output logic [7:0]  mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err
);

    // Byte counter width: covers byte addresses 0..NUM_INSTR*4-1.
    localparam int          CW      = $clog2(NUM_INSTR) + 2;
    localparam logic [15:0] MAX_LEN = 16'(NUM_INSTR);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_LOAD = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] last_q, last_d;
    logic          we_q, we_d;
    logic [CW-1:0] waddr_q, waddr_d;
    logic [7:0]    wdata_q, wdata_d;
    logic          done_q, done_d;
    logic          err_q, err_d;

    logic accept;
    logic len_ok;

    assign byte_ready = (state_q == ST_LOAD);
    assign accept     = byte_valid && byte_ready;
    assign len_ok     = (load_len != 16'd0) && (load_len <= MAX_LEN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    if (len_ok) begin
                        // load_len*4-1 taken modulo 2^CW; the true value always fits in CW bits.
                        last_d  = {load_len[CW-3:0], 2'b00} - CW'(1);
                        cnt_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                if (accept) begin
                    we_d    = 1'b1;
                    waddr_d = cnt_q;
                    wdata_d = byte_data;
                    if (cnt_q == last_q) begin
                        // Counter stays at last so it can never run past the loaded region.
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_waddr = {{(32-CW){1'b0}}, waddr_q};
    assign mem_wdata = wdata_q;
    assign done      = done_q;
    assign err       = err_q;

    assign busy       = (state_q != ST_IDLE);
    assign core_stall = busy;

    // While loading, memory contents are in flux: park the read port and feed the core NOPs.
    assign mem_raddr  = busy ? 32'h0 : core_addr;
    assign core_instr = busy ? NOP_INSTR : mem_rdata;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int          NUM_INSTR = 32;
    localparam int          NB        = NUM_INSTR * 4;
    localparam logic [31:0] NOP       = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        load_start;
    logic [15:0] load_len;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic [31:0] core_addr;
    logic [31:0] core_instr;
    logic        core_stall;
    logic [31:0] mem_raddr;
    logic [31:0] mem_rdata;
    logic        mem_we;
    logic [31:0] mem_waddr;
    logic [7:0]  mem_wdata;
    logic        busy;
    logic        done;
    logic        err;

    imem_loader #(.NUM_INSTR(NUM_INSTR), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst),
        .load_start(load_start), .load_len(load_len),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
        .core_addr(core_addr), .core_instr(core_instr), .core_stall(core_stall),
        .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Instruction memory environment: big-endian byte array, combinational read.
    logic [7:0] mem [0:NB-1];
    logic [6:0] ra;
    assign ra        = mem_raddr[6:0];
    assign mem_rdata = {mem[ra], mem[ra + 7'd1], mem[ra + 7'd2], mem[ra + 7'd3]};

    initial begin
        for (int i = 0; i < NB; i++) mem[i] <= 8'(i) ^ 8'hA5;
    end
    always @(posedge clk) begin
        if (mem_we === 1'b1 && mem_waddr < NB) mem[mem_waddr[6:0]] <= mem_wdata;
    end

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        logic [6:0] i;
        i = a[6:0];
        return {mem[i], mem[i + 7'd1], mem[i + 7'd2], mem[i + 7'd3]};
    endfunction

    // Passive log of every write and status pulse (read by tests only at posedge+1).
    logic [31:0] wr_addr_q[$];
    logic [7:0]  wr_data_q[$];
    int          done_cnt = 0;
    int          err_cnt  = 0;
    always @(negedge clk) begin
        if (mem_we === 1'b1) begin
            wr_addr_q.push_back(mem_waddr);
            wr_data_q.push_back(mem_wdata);
        end
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
    end

    int         errors = 0;
    int         checks = 0;
    logic [7:0] stream_q[$];

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [15:0] len);
        load_start = 1'b1;
        load_len   = len;
        cyc();
        load_start = 1'b0;
    endtask

    task automatic fill_stream(input int n);
        stream_q.delete();
        for (int i = 0; i < n; i++) stream_q.push_back(8'($urandom));
    endtask

    // Streams stream_q[first +: n] with up to gap_max idle cycles before each byte.
    // Every waited cycle is inside LOAD, so the fetch path must be gated.
    task automatic send_bytes(input int first, input int n, input int gap_max);
        int  gaps;
        bit  acc;
        for (int i = first; i < first + n; i++) begin
            gaps = int'($urandom_range(gap_max, 0));
            byte_valid = 1'b0;
            repeat (gaps) cyc();
            byte_valid = 1'b1;
            byte_data  = stream_q[i];
            acc = 1'b0;
            for (int t = 0; t < 40 && !acc; t++) begin
                @(negedge clk);
                checks++;
                if (busy !== 1'b1 || core_stall !== 1'b1 || core_instr !== NOP || mem_raddr !== 32'h0) begin
                    errors++;
                    $display("FAIL load_gate: busy=%b stall=%b instr=%h raddr=%h, required 1 1 %h 0",
                             busy, core_stall, core_instr, mem_raddr, NOP);
                end
                if (byte_ready === 1'b1) acc = 1'b1;
                cyc();
            end
            if (!acc) begin
                checks++;
                errors++;
                $display("FAIL accept_timeout: byte %0d not accepted within 40 cycles", i);
            end
        end
        byte_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; load_start = 1'b0; load_len = '0; byte_valid = 1'b0; byte_data = '0; core_addr = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++; if (mem_we !== 1'b0)     begin errors++; $display("FAIL rst_we: got %b want 0", mem_we); end
        checks++; if (mem_waddr !== 32'h0) begin errors++; $display("FAIL rst_waddr: got %h want 0", mem_waddr); end
        checks++; if (mem_wdata !== 8'h0)  begin errors++; $display("FAIL rst_wdata: got %h want 0", mem_wdata); end
        checks++; if (done !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL rst_pulses: done=%b err=%b want 0 0", done, err); end
        checks++; if (busy !== 1'b0 || core_stall !== 1'b0 || byte_ready !== 1'b0) begin
            errors++; $display("FAIL rst_status: busy=%b stall=%b ready=%b want 0 0 0", busy, core_stall, byte_ready);
        end
        cyc();
        rst = 1'b0;
        cyc();
    endtask

    task automatic test_single();
        logic [7:0] b [4];
        int d0;
        b[0] = 8'h00; b[1] = 8'h50; b[2] = 8'h00; b[3] = 8'h93;
        d0 = done_cnt;
        start_load(16'd1);
        for (int k = 0; k <= 4; k++) begin
            byte_valid = (k < 4);
            byte_data  = (k < 4) ? b[k] : 8'h00;
            @(negedge clk);
            checks++;
            if (mem_we !== (k > 0)) begin errors++; $display("FAIL single_we[%0d]: got %b want %b", k, mem_we, (k > 0)); end
            if (k > 0) begin
                checks++;
                if (mem_waddr !== 32'(k - 1) || mem_wdata !== b[k-1]) begin
                    errors++; $display("FAIL single_wr[%0d]: got %h/%h want %h/%h", k, mem_waddr, mem_wdata, k - 1, b[k-1]);
                end
            end
            checks++;
            if (done !== (k == 4) || byte_ready !== (k < 4)) begin
                errors++; $display("FAIL single_done_ready[%0d]: done=%b ready=%b want %b %b", k, done, byte_ready, (k == 4), (k < 4));
            end
            cyc();
        end
        core_addr = 32'h0;
        @(negedge clk);
        checks++; if (core_stall !== 1'b0) begin errors++; $display("FAIL single_stall_fall: got %b want 0", core_stall); end
        checks++; if (core_instr !== 32'h00500093) begin errors++; $display("FAIL single_fetch: got %h want 00500093", core_instr); end
        cyc();
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL single_done_count: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_toggle();
        int d0;
        bit ew;
        fill_stream(8);
        d0 = done_cnt;
        start_load(16'd2);
        for (int c = 0; c < 16; c++) begin
            byte_valid = (c % 2 == 0);
            byte_data  = stream_q[c / 2];
            ew = (c % 2 == 1);
            @(negedge clk);
            checks++;
            if (mem_we !== ew || byte_ready !== (c < 15) || done !== (c == 15)) begin
                errors++; $display("FAIL toggle_ctl[%0d]: we=%b ready=%b done=%b want %b %b %b",
                                   c, mem_we, byte_ready, done, ew, (c < 15), (c == 15));
            end
            if (ew) begin
                checks++;
                if (mem_waddr !== 32'((c - 1) / 2) || mem_wdata !== stream_q[(c - 1) / 2]) begin
                    errors++; $display("FAIL toggle_wr[%0d]: got %h/%h want %h/%h", c, mem_waddr, mem_wdata, (c - 1) / 2, stream_q[(c - 1) / 2]);
                end
            end
            cyc();
        end
        byte_valid = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL toggle_idle: busy=%b want 0", busy); end
        cyc();
        checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL toggle_done_count: got %0d want 1", done_cnt - d0); end
    endtask

    task automatic test_err();
        logic [15:0] lens [2];
        int e0, base;
        lens[0] = 16'd0; lens[1] = 16'(NUM_INSTR + 1);
        for (int j = 0; j < 2; j++) begin
            e0 = err_cnt; base = wr_addr_q.size();
            load_start = 1'b1; load_len = lens[j];
            @(negedge clk);
            checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_early[%0d]: got %b want 0", lens[j], err); end
            cyc();
            load_start = 1'b0;
            @(negedge clk);
            checks++; if (err !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL err_pulse[%0d]: err=%b busy=%b want 1 0", lens[j], err, busy); end
            cyc();
            @(negedge clk);
            checks++; if (err !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL err_after[%0d]: err=%b busy=%b want 0 0", lens[j], err, busy); end
            cyc();
            checks++; if (err_cnt - e0 !== 1 || wr_addr_q.size() !== base) begin
                errors++; $display("FAIL err_count[%0d]: pulses=%0d writes=%0d want 1 0", lens[j], err_cnt - e0, wr_addr_q.size() - base);
            end
        end
    endtask

    task automatic test_fetch();
        fill_stream(4);
        core_addr = 32'h8;
        start_load(16'd1);
        send_bytes(0, 4, 1);
        @(negedge clk);
        checks++; if (core_instr !== NOP || mem_raddr !== 32'h0 || done !== 1'b1) begin
            errors++; $display("FAIL fetch_fin: instr=%h raddr=%h done=%b want %h 0 1", core_instr, mem_raddr, done, NOP);
        end
        cyc();
        @(negedge clk);
        checks++; if (mem_raddr !== 32'h8 || core_instr !== rd_word(32'h8)) begin
            errors++; $display("FAIL fetch_follow: raddr=%h instr=%h want 8 %h", mem_raddr, core_instr, rd_word(32'h8));
        end
        core_addr = 32'h0;
        #1;
        checks++; if (core_instr !== {stream_q[0], stream_q[1], stream_q[2], stream_q[3]}) begin
            errors++; $display("FAIL fetch_loaded: got %h want %h", core_instr, {stream_q[0], stream_q[1], stream_q[2], stream_q[3]});
        end
        cyc();
    endtask

    task automatic test_async_rst();
        int d0, base;
        fill_stream(8);
        d0 = done_cnt;
        start_load(16'd2);
        send_bytes(0, 5, 0);
        checks++; if (mem_we !== 1'b1) begin errors++; $display("FAIL arst_pending: we=%b want 1", mem_we); end
        byte_valid = 1'b1; byte_data = stream_q[5];
        #1 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0 || core_stall !== 1'b0 || mem_we !== 1'b0 || byte_ready !== 1'b0) begin
            errors++; $display("FAIL arst_drop: busy=%b stall=%b we=%b ready=%b want 0 0 0 0", busy, core_stall, mem_we, byte_ready);
        end
        cyc();
        byte_valid = 1'b0;
        rst = 1'b0;
        cyc();
        checks++; if (done_cnt !== d0) begin errors++; $display("FAIL arst_no_done: got %0d extra done want 0", done_cnt - d0); end
        fill_stream(4);
        base = wr_addr_q.size();
        start_load(16'd1);
        send_bytes(0, 4, 0);
        cyc();
        checks++;
        if (wr_addr_q.size() - base !== 4) begin
            errors++; $display("FAIL arst_reload_count: got %0d writes want 4", wr_addr_q.size() - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_addr_q[base+i] !== 32'(i) || wr_data_q[base+i] !== stream_q[i]) begin
                    errors++; $display("FAIL arst_reload[%0d]: got %h/%h want %h/%h", i, wr_addr_q[base+i], wr_data_q[base+i], i, stream_q[i]);
                end
            end
        end
    endtask

    task automatic test_ignored_start();
        int d0, e0, base;
        fill_stream(12);
        d0 = done_cnt; e0 = err_cnt; base = wr_addr_q.size();
        start_load(16'd3);
        send_bytes(0, 2, 0);
        load_start = 1'b1; load_len = 16'd5;
        send_bytes(2, 1, 0);
        load_start = 1'b0;
        send_bytes(3, 9, 1);
        load_start = 1'b1; load_len = 16'd2;   // lands in the FIN cycle
        @(negedge clk);
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL ign_fin_done: got %b want 1", done); end
        cyc();
        load_start = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_fin_start: busy=%b want 0", busy); end
        cyc();
        checks++; if (err_cnt !== e0 || done_cnt - d0 !== 1 || wr_addr_q.size() - base !== 12) begin
            errors++; $display("FAIL ign_counts: err=%0d done=%0d writes=%0d want 0 1 12", err_cnt - e0, done_cnt - d0, wr_addr_q.size() - base);
        end
    endtask

    task automatic test_random();
        int len, d0, base, w;
        logic [31:0] exp_w;
        for (int it = 0; it < 6; it++) begin
            len = (it == 0) ? NUM_INSTR : int'($urandom_range(NUM_INSTR, 1));
            fill_stream(len * 4);
            d0 = done_cnt; base = wr_addr_q.size();
            start_load(16'(len));
            send_bytes(0, len * 4, 2);
            cyc();
            checks++; if (done_cnt - d0 !== 1) begin errors++; $display("FAIL rand_done[%0d]: got %0d want 1", it, done_cnt - d0); end
            checks++;
            if (wr_addr_q.size() - base !== len * 4) begin
                errors++; $display("FAIL rand_count[%0d]: got %0d writes want %0d", it, wr_addr_q.size() - base, len * 4);
            end else begin
                for (int i = 0; i < len * 4; i++) begin
                    checks++;
                    if (wr_addr_q[base+i] !== 32'(i) || wr_data_q[base+i] !== stream_q[i]) begin
                        errors++; $display("FAIL rand_wr[%0d.%0d]: got %h/%h want %h/%h", it, i, wr_addr_q[base+i], wr_data_q[base+i], i, stream_q[i]);
                    end
                end
            end
            for (int k = 0; k < 3; k++) begin
                w = int'($urandom_range(len - 1, 0));
                exp_w = {stream_q[4*w], stream_q[4*w+1], stream_q[4*w+2], stream_q[4*w+3]};
                core_addr = 32'(w * 4);
                @(negedge clk);
                checks++; if (core_instr !== exp_w || core_stall !== 1'b0) begin
                    errors++; $display("FAIL rand_fetch[%0d]: addr=%h got %h stall=%b want %h 0", it, core_addr, core_instr, core_stall, exp_w);
                end
                cyc();
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_toggle();
        test_err();
        test_fetch();
        test_async_rst();
        test_ignored_start();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
